main_memory_resp: RTL and testbench

- Main-memory responder at the far end of the MAR/MDR and PC/MBR interfaces of the MIC datapath.
- Accepts word read/write requests addressed by MAR, with write data from MDR, and returns read words to MDR after a fixed latency.
- Serves the independent byte-fetch port (PC address, MBR byte) in parallel.
- Contents are held in an internal word array and are not cleared by reset.

---
 rtl/main_memory_resp_if.sv | 26 ++
 rtl/main_memory_resp.sv | 213 +++++++++++++++++++++
 tb/tb_main_memory_resp.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_resp_if.sv
// Word (MAR/MDR) and byte-fetch (PC/MBR) buses between the MIC datapath and main memory.
interface main_memory_resp_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr_word;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        wr_done;
  logic        busy;
  logic        fetch;
  logic [31:0] pc_addr;
  logic [7:0]  mbr_out;
  logic        mbr_valid;
  logic        err;

  modport master (
    output rd, wr, addr_word, wdata, fetch, pc_addr,
    input  rdata, rdata_valid, wr_done, busy, mbr_out, mbr_valid, err
  );

  modport slave (
    input  rd, wr, addr_word, wdata, fetch, pc_addr,
    output rdata, rdata_valid, wr_done, busy, mbr_out, mbr_valid, err
  );
endinterface

// File: rtl/main_memory_resp.sv
// Fixed-latency main memory with a word port and an independent byte-fetch port.
// Optional out-of-range error reporting is enabled by defining MEM_ERR_EN.
module main_memory_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  main_memory_resp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LOAD   = 4'(LATENCY - 1);
  localparam bit         DIRECT = (LATENCY == 1);

  logic [31:0] mem [2**ADDR_W];

  state_t              wstate, wstate_next, fstate, fstate_next;
  logic [3:0]          wcnt, fcnt;
  logic                w_accept, w_complete, f_accept, f_complete;
  logic                w_err_in, f_err_in, w_commit;
  logic                w_wr_q, w_err_q, f_err_q;
  logic [ADDR_W-1:0]   w_idx_q, f_idx_q;
  logic [31:0]         w_data_q;
  logic [1:0]          f_sel_q;
  logic                wc_wr, wc_err, fc_err;
  logic [ADDR_W-1:0]   wc_idx, fc_idx;
  logic [31:0]         wc_data, f_word;
  logic [1:0]          fc_sel;
  logic [31:0]         rdata_q;
  logic                rdata_valid_q, wr_done_q, mbr_valid_q;
  logic [7:0]          mbr_q;

`ifdef MEM_ERR_EN
  assign w_err_in = (bus.addr_word >> ADDR_W) != 32'd0;
  assign f_err_in = (bus.pc_addr >> (ADDR_W + 2)) != 32'd0;
`else
  assign w_err_in = 1'b0;
  assign f_err_in = 1'b0;
`endif

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate <= IDLE;
      fstate <= IDLE;
    end else begin
      wstate <= wstate_next;
      fstate <= fstate_next;
    end
  end

  // DONE behaves like IDLE for acceptance so requests can run back to back.
  always_comb begin
    wstate_next = wstate;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (wstate)
      IDLE, DONE: begin
        wstate_next = IDLE;
        if (bus.rd || bus.wr) begin
          w_accept = 1'b1;
          if (DIRECT) begin
            w_complete  = 1'b1;
            wstate_next = DONE;
          end else begin
            wstate_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt <= 4'd1) begin
          w_complete  = 1'b1;
          wstate_next = DONE;
        end
      end
      default: wstate_next = IDLE;
    endcase
  end

  always_comb begin
    fstate_next = fstate;
    f_accept    = 1'b0;
    f_complete  = 1'b0;
    case (fstate)
      IDLE, DONE: begin
        fstate_next = IDLE;
        if (bus.fetch) begin
          f_accept = 1'b1;
          if (DIRECT) begin
            f_complete  = 1'b1;
            fstate_next = DONE;
          end else begin
            fstate_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (fcnt <= 4'd1) begin
          f_complete  = 1'b1;
          fstate_next = DONE;
        end
      end
      default: fstate_next = IDLE;
    endcase
  end

  // With single-cycle latency the completing request comes straight from the ports.
  always_comb begin
    if (DIRECT) begin
      wc_wr   = bus.wr;
      wc_idx  = bus.addr_word[ADDR_W-1:0];
      wc_data = bus.wdata;
      wc_err  = w_err_in;
      fc_idx  = bus.pc_addr[ADDR_W+1:2];
      fc_sel  = bus.pc_addr[1:0];
      fc_err  = f_err_in;
    end else begin
      wc_wr   = w_wr_q;
      wc_idx  = w_idx_q;
      wc_data = w_data_q;
      wc_err  = w_err_q;
      fc_idx  = f_idx_q;
      fc_sel  = f_sel_q;
      fc_err  = f_err_q;
    end
  end

  assign w_commit = w_complete && wc_wr && !wc_err && !reset;

  // Write-first forwarding when a fetch lands on the word being committed.
  assign f_word = (w_commit && (wc_idx == fc_idx)) ? wc_data : mem[fc_idx];

  always_ff @(posedge clk) begin
    if (w_commit) mem[wc_idx] <= wc_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      wcnt          <= '0;
      w_wr_q        <= 1'b0;
      w_err_q       <= 1'b0;
      w_idx_q       <= '0;
      w_data_q      <= '0;
    end else begin
      rdata_valid_q <= w_complete && !wc_wr && !wc_err;
      wr_done_q     <= w_complete && wc_wr && !wc_err;
      if (w_complete && !wc_wr && !wc_err) rdata_q <= mem[wc_idx];
      if (w_accept) begin
        wcnt     <= LOAD;
        w_wr_q   <= bus.wr;
        w_err_q  <= w_err_in;
        w_idx_q  <= bus.addr_word[ADDR_W-1:0];
        w_data_q <= bus.wdata;
      end else if (wstate == WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mbr_q       <= '0;
      mbr_valid_q <= 1'b0;
      fcnt        <= '0;
      f_err_q     <= 1'b0;
      f_idx_q     <= '0;
      f_sel_q     <= '0;
    end else begin
      mbr_valid_q <= f_complete && !fc_err;
      if (f_complete) mbr_q <= fc_err ? 8'h00 : pick_byte(f_word, fc_sel);
      if (f_accept) begin
        fcnt    <= LOAD;
        f_err_q <= f_err_in;
        f_idx_q <= bus.pc_addr[ADDR_W+1:2];
        f_sel_q <= bus.pc_addr[1:0];
      end else if (fstate == WAIT) begin
        fcnt <= fcnt - 4'd1;
      end
    end
  end

`ifdef MEM_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= (w_complete && wc_err) || (f_complete && fc_err);
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.busy        = (wstate == WAIT);
  assign bus.mbr_out     = mbr_q;
  assign bus.mbr_valid   = mbr_valid_q;

endmodule

// File: tb/tb_main_memory_resp.sv
// Scoreboard bench for main_memory_resp: a LATENCY=2 instance for the main flow
// and a LATENCY=1 instance for the write/fetch collision case.
module tb_main_memory_resp;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   busy1Seen = 0;

  exp_t rdQ[$], wrQ[$], mbQ[$], errQ[$], mb1Q[$], wr1Q[$];

  main_memory_resp_if bus();
  main_memory_resp_if bus1();

  main_memory_resp #(.ADDR_W(10), .LATENCY(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
  main_memory_resp #(.ADDR_W(10), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    tests++;
    failed++;
    $display("[TB] FAIL %s: unexpected output %h at cycle %0d, expected none", name, actual, cyc);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic fetch, input logic [31:0] pc);
    bus.rd        = rd;
    bus.wr        = wr;
    bus.addr_word = addr;
    bus.wdata     = wdata;
    bus.fetch     = fetch;
    bus.pc_addr   = pc;
    @(posedge clk);
    #1;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.fetch = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectRead(input logic [31:0] d);
    rdQ.push_back('{d, cyc + 2});
  endtask

  task automatic expectWrite();
    wrQ.push_back('{32'h0, cyc + 2});
  endtask

  task automatic expectFetch(input logic [7:0] b);
    mbQ.push_back('{{24'h0, b}, cyc + 2});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdata"},       bus.rdata, 32'h0);
    checkOutput({tag, "_rdata_valid"}, {31'h0, bus.rdata_valid}, 32'h0);
    checkOutput({tag, "_wr_done"},     {31'h0, bus.wr_done}, 32'h0);
    checkOutput({tag, "_busy"},        {31'h0, bus.busy}, 32'h0);
    checkOutput({tag, "_mbr_out"},     {24'h0, bus.mbr_out}, 32'h0);
    checkOutput({tag, "_mbr_valid"},   {31'h0, bus.mbr_valid}, 32'h0);
    checkOutput({tag, "_err"},         {31'h0, bus.err}, 32'h0);
  endtask

  // Monitor for the LATENCY=2 instance: pops and compares whenever an output pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.rdata_valid) begin
        if (rdQ.size() == 0) reportUnexpected("rdata_valid", bus.rdata);
        else begin
          e = rdQ.pop_front();
          checkOutput("rdata", bus.rdata, e.data);
          checkOutput("rdata_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.wr_done) begin
        if (wrQ.size() == 0) reportUnexpected("wr_done", 32'h1);
        else begin
          e = wrQ.pop_front();
          checkOutput("wr_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.mbr_valid) begin
        if (mbQ.size() == 0) reportUnexpected("mbr_valid", {24'h0, bus.mbr_out});
        else begin
          e = mbQ.pop_front();
          checkOutput("mbr_out", {24'h0, bus.mbr_out}, e.data);
          checkOutput("mbr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.err) begin
        if (errQ.size() == 0) reportUnexpected("err", 32'h1);
        else begin
          e = errQ.pop_front();
          checkOutput("err_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus1.busy) busy1Seen++;
      if (bus1.rdata_valid) reportUnexpected("lat1_rdata_valid", bus1.rdata);
      if (bus1.wr_done) begin
        if (wr1Q.size() == 0) reportUnexpected("lat1_wr_done", 32'h1);
        else begin
          e = wr1Q.pop_front();
          checkOutput("lat1_wr_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus1.mbr_valid) begin
        if (mb1Q.size() == 0) reportUnexpected("lat1_mbr_valid", {24'h0, bus1.mbr_out});
        else begin
          e = mb1Q.pop_front();
          checkOutput("lat1_mbr_out", {24'h0, bus1.mbr_out}, e.data);
          checkOutput("lat1_mbr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.rd         = 1'b0;
    bus.wr         = 1'b0;
    bus.addr_word  = '0;
    bus.wdata      = '0;
    bus.fetch      = 1'b0;
    bus.pc_addr    = '0;
    bus1.rd        = 1'b0;
    bus1.wr        = 1'b0;
    bus1.addr_word = '0;
    bus1.wdata     = '0;
    bus1.fetch     = 1'b0;
    bus1.pc_addr   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    idle(1);

    // Write then read back word 5.
    expectWrite();
    applyStimulus(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    checkOutput("busy_write", {31'h0, bus.busy}, 32'h1);
    idle(1);
    checkOutput("busy_write_done", {31'h0, bus.busy}, 32'h0);
    expectRead(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'd0);
    checkOutput("busy_read", {31'h0, bus.busy}, 32'h1);
    idle(2);

    // Big-endian byte fetch of word 5, one request per latency window.
    expectFetch(8'hDE); applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'd20); idle(1);
    expectFetch(8'hAD); applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'd21); idle(1);
    expectFetch(8'hBE); applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'd22); idle(1);
    expectFetch(8'hEF); applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'd23); idle(2);

    // Read while busy is dropped; rd+wr together performs only the write.
    expectRead(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd6, 32'h0, 1'b0, 32'd0);
    expectWrite();
    applyStimulus(1'b1, 1'b1, 32'd6, 32'h12345678, 1'b0, 32'd0);
    idle(1);
    expectRead(32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'd6, 32'h0, 1'b0, 32'd0);
    idle(2);

    expectWrite();
    applyStimulus(1'b0, 1'b1, 32'd7, 32'h11112222, 1'b0, 32'd0);
    idle(2);

    // Reset one cycle into a write to word 7 must abort the commit.
    applyStimulus(1'b0, 1'b1, 32'd7, 32'hA5A5A5A5, 1'b0, 32'd0);
    reset = 1'b1;
    idle(1);
    checkAllZero("midreset");
    reset = 1'b0;
    idle(1);

    expectRead(32'h11112222);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 32'd0);
    idle(2);

    // Upper address bits: wrap by default, error when MEM_ERR_EN is defined.
`ifdef MEM_ERR_EN
    errQ.push_back('{32'h0, cyc + 2});
`else
    expectRead(32'hDEADBEEF);
`endif
    applyStimulus(1'b1, 1'b0, 32'h405, 32'h0, 1'b0, 32'd0);
    idle(2);
`ifdef MEM_ERR_EN
    checkOutput("err_rdata_held", bus.rdata, 32'h11112222);
`else
    checkOutput("wrap_rdata_held", bus.rdata, 32'hDEADBEEF);
`endif

    expectRead(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'd0);
    idle(2);

    // LATENCY=1: write word 9 and fetch its top byte on the same edge.
    wr1Q.push_back('{32'h0, cyc + 1});
    mb1Q.push_back('{32'h01, cyc + 1});
    bus1.wr        = 1'b1;
    bus1.addr_word = 32'd9;
    bus1.wdata     = 32'h01020304;
    bus1.fetch     = 1'b1;
    bus1.pc_addr   = 32'd36;
    @(posedge clk);
    #1;
    bus1.wr = 1'b0;
    mb1Q.push_back('{32'h04, cyc + 1});
    bus1.pc_addr = 32'd39;
    @(posedge clk);
    #1;
    bus1.fetch = 1'b0;
    idle(3);

    checkOutput("lat1_busy_never", 32'(busy1Seen), 32'h0);
    checkOutput("rdQ_drained",  32'(rdQ.size()),  32'h0);
    checkOutput("wrQ_drained",  32'(wrQ.size()),  32'h0);
    checkOutput("mbQ_drained",  32'(mbQ.size()),  32'h0);
    checkOutput("errQ_drained", 32'(errQ.size()), 32'h0);
    checkOutput("mb1Q_drained", 32'(mb1Q.size()), 32'h0);
    checkOutput("wr1Q_drained", 32'(wr1Q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
